// File: rtl/pcie_dllp_tx_scheduler.sv
// pcie_dllp_tx_scheduler
//   Data-link-layer DLLP transmit scheduler. Runs flow-control initialization
//   (repeated InitFC1 then InitFC2 triplets), then in DL_ACTIVE arbitrates
//   Ack/Nak and UpdateFC traffic onto one 32-bit DLLP stream (no CRC).
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   link_up_i               physical LinkUp; low forces DL_DOWN and flushes
//   fc1_rcvd_i, fc2_rcvd_i  peer InitFC1 / InitFC2 (or later traffic) seen
//   acknak_req_i/_nak_i/_seq_i  one-cycle Ack/Nak request with its fields
//   upd_req_i[2:0]          one-cycle UpdateFC requests {Cpl, NP, P}
//   fc_hdr_i, fc_data_i     current advertised credits {Cpl, NP, P}
//   m_dllp_tdata/tvalid/tready  DLLP bytes 0..3 (byte0 in [7:0]), handshake
//   dl_status_o             0 DL_DOWN, 1 DL_UP, 2 DL_ACTIVE
//   acknak_pending_o        Ack/Nak latched and not yet accepted downstream
module pcie_dllp_tx_scheduler #(
  parameter logic [7:0]  P_HDR_FC           = 8'h08,
  parameter logic [11:0] P_DATA_FC          = 12'h200,
  parameter logic [7:0]  NP_HDR_FC          = 8'h08,
  parameter logic [11:0] NP_DATA_FC         = 12'h080,
  parameter logic [7:0]  CPL_HDR_FC         = 8'h00,
  parameter logic [11:0] CPL_DATA_FC        = 12'h000,
  parameter int unsigned FC_INIT_GAP        = 16,
  parameter int unsigned UPDATE_FC_INTERVAL = 1000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        link_up_i,
  input  logic        fc1_rcvd_i,
  input  logic        fc2_rcvd_i,
  input  logic        acknak_req_i,
  input  logic        acknak_nak_i,
  input  logic [11:0] acknak_seq_i,
  input  logic [2:0]  upd_req_i,
  input  logic [23:0] fc_hdr_i,
  input  logic [35:0] fc_data_i,
  output logic [31:0] m_dllp_tdata,
  output logic        m_dllp_tvalid,
  input  logic        m_dllp_tready,
  output logic [1:0]  dl_status_o,
  output logic        acknak_pending_o
);

  typedef enum logic [1:0] {ST_DOWN, ST_INIT1, ST_INIT2, ST_ACTIVE} state_t;

  // The gap counter is loaded on the Cpl acceptance edge, which already
  // counts as the first idle cycle, hence the minus one.
  localparam logic [15:0] GAP_RELOAD = (FC_INIT_GAP == 0) ? 16'd0 : 16'(FC_INIT_GAP - 1);
  localparam logic [31:0] TMR_LAST   = 32'(UPDATE_FC_INTERVAL - 1);

  function automatic logic [31:0] enc_fc(input logic [7:0] typ, input logic [7:0] hdr,
                                         input logic [11:0] data);
    return {data[7:0], hdr[1:0], 2'b00, data[11:8], 2'b00, hdr[7:2], typ};
  endfunction

  function automatic logic [31:0] enc_acknak(input logic nak, input logic [11:0] seq);
    return {seq[7:0], 4'h0, seq[11:8], 8'h00, (nak ? 8'h10 : 8'h00)};
  endfunction

  function automatic logic [31:0] init_beat(input logic second, input logic [1:0] idx);
    logic [31:0] beat;
    case (idx)
      2'd0:    beat = enc_fc(second ? 8'hC0 : 8'h40, P_HDR_FC, P_DATA_FC);
      2'd1:    beat = enc_fc(second ? 8'hD0 : 8'h50, NP_HDR_FC, NP_DATA_FC);
      default: beat = enc_fc(second ? 8'hE0 : 8'h60, CPL_HDR_FC, CPL_DATA_FC);
    endcase
    return beat;
  endfunction

  state_t      state_q, state_d;
  logic        tvalid_q, tvalid_d;
  logic [31:0] tdata_q, tdata_d;
  logic [1:0]  idx_q, idx_d;        // next InitFC beat; 3 = Cpl presented
  logic [15:0] gap_q, gap_d;
  logic [31:0] tmr_q, tmr_d;
  logic        an_q, an_d;          // Ack/Nak latched, not yet loaded
  logic        an_nak_q, an_nak_d;
  logic [11:0] an_seq_q, an_seq_d;
  logic [2:0]  upd_q, upd_d;        // UpdateFC latched, not yet loaded
  logic        cur_an_q, cur_an_d;  // presented beat is the Ack/Nak
  logic [1:0]  dl_status_q, dl_status_d;
  logic        acknak_pending_q, acknak_pending_d;

  logic       accept, out_free, rcvd, tmr_set, an_clr;
  logic [2:0] upd_clr;

  always_comb begin
    state_d  = state_q;
    tvalid_d = tvalid_q & ~m_dllp_tready;
    tdata_d  = tdata_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    tmr_d    = tmr_q;
    an_d     = an_q;
    an_nak_d = an_nak_q;
    an_seq_d = an_seq_q;
    upd_d    = upd_q;
    cur_an_d = cur_an_q;
    accept   = tvalid_q & m_dllp_tready;
    out_free = ~tvalid_q | m_dllp_tready;
    rcvd     = (state_q == ST_INIT1) ? fc1_rcvd_i : fc2_rcvd_i;
    tmr_set  = 1'b0;
    an_clr   = 1'b0;
    upd_clr  = 3'b000;

    if (!link_up_i) begin
      // Link loss flushes everything, including a beat mid-handshake.
      state_d  = ST_DOWN;
      tvalid_d = 1'b0;
      idx_d    = 2'd0;
      gap_d    = 16'd0;
      tmr_d    = 32'd0;
      an_d     = 1'b0;
      upd_d    = 3'b000;
      cur_an_d = 1'b0;
    end else begin
      case (state_q)
        ST_DOWN: begin
          state_d = ST_INIT1;
          idx_d   = 2'd0;
          gap_d   = 16'd0;
        end
        ST_INIT1, ST_INIT2: begin
          if (idx_q == 2'd3 && accept) begin
            if (rcvd) begin
              state_d = (state_q == ST_INIT1) ? ST_INIT2 : ST_ACTIVE;
              idx_d   = 2'd0;
              gap_d   = 16'd0;
              tmr_d   = 32'd0;
            end else if (FC_INIT_GAP == 0) begin
              tdata_d  = init_beat(state_q == ST_INIT2, 2'd0);
              tvalid_d = 1'b1;
              cur_an_d = 1'b0;
              idx_d    = 2'd1;
            end else begin
              gap_d = GAP_RELOAD;
              idx_d = 2'd0;
            end
          end else if (gap_q != 16'd0) begin
            gap_d = gap_q - 16'd1;
          end else if (idx_q != 2'd3 && out_free) begin
            tdata_d  = init_beat(state_q == ST_INIT2, idx_q);
            tvalid_d = 1'b1;
            cur_an_d = 1'b0;
            idx_d    = idx_q + 2'd1;
          end
        end
        default: begin
          // Only latched requests are eligible, so a request costs one cycle
          // and a presented beat is never displaced.
          if (out_free) begin
            if (an_q) begin
              tdata_d  = enc_acknak(an_nak_q, an_seq_q);
              tvalid_d = 1'b1;
              cur_an_d = 1'b1;
              an_clr   = 1'b1;
            end else if (upd_q[0]) begin
              tdata_d  = enc_fc(8'h80, fc_hdr_i[7:0], fc_data_i[11:0]);
              tvalid_d = 1'b1;
              cur_an_d = 1'b0;
              upd_clr  = 3'b001;
            end else if (upd_q[1]) begin
              tdata_d  = enc_fc(8'h90, fc_hdr_i[15:8], fc_data_i[23:12]);
              tvalid_d = 1'b1;
              cur_an_d = 1'b0;
              upd_clr  = 3'b010;
            end else if (upd_q[2]) begin
              tdata_d  = enc_fc(8'hA0, fc_hdr_i[23:16], fc_data_i[35:24]);
              tvalid_d = 1'b1;
              cur_an_d = 1'b0;
              upd_clr  = 3'b100;
            end
          end
          tmr_set = (tmr_q == TMR_LAST);
          tmr_d   = tmr_set ? 32'd0 : tmr_q + 32'd1;
          // New requests win over the clear of the slot being loaded.
          an_d  = (an_q & ~an_clr) | acknak_req_i;
          upd_d = (upd_q & ~upd_clr) | upd_req_i | {3{tmr_set}};
          if (acknak_req_i) begin
            an_nak_d = acknak_nak_i;
            an_seq_d = acknak_seq_i;
          end
        end
      endcase
    end

    case (state_d)
      ST_DOWN:   dl_status_d = 2'd0;
      ST_ACTIVE: dl_status_d = 2'd2;
      default:   dl_status_d = 2'd1;
    endcase
    // Pending covers both the latched slot and a presented, unaccepted beat.
    acknak_pending_d = an_d | (tvalid_d & cur_an_d);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= ST_DOWN;
      tvalid_q         <= 1'b0;
      tdata_q          <= 32'd0;
      idx_q            <= 2'd0;
      gap_q            <= 16'd0;
      tmr_q            <= 32'd0;
      an_q             <= 1'b0;
      upd_q            <= 3'b000;
      cur_an_q         <= 1'b0;
      dl_status_q      <= 2'd0;
      acknak_pending_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      tvalid_q         <= tvalid_d;
      tdata_q          <= tdata_d;
      idx_q            <= idx_d;
      gap_q            <= gap_d;
      tmr_q            <= tmr_d;
      an_q             <= an_d;
      upd_q            <= upd_d;
      cur_an_q         <= cur_an_d;
      dl_status_q      <= dl_status_d;
      acknak_pending_q <= acknak_pending_d;
    end
  end

  // Ack/Nak fields are only meaningful while an_q is set.
  always_ff @(posedge clk_i) begin
    an_nak_q <= an_nak_d;
    an_seq_q <= an_seq_d;
  end

  assign m_dllp_tdata     = tdata_q;
  assign m_dllp_tvalid    = tvalid_q;
  assign dl_status_o      = dl_status_q;
  assign acknak_pending_o = acknak_pending_q;

endmodule

// File: tb/tb_pcie_dllp_tx_scheduler.sv
module tb_pcie_dllp_tx_scheduler;

  localparam int INTERVAL = 10;
  localparam int GAP      = 16;

  logic        clk, rst, link_up, fc1_rcvd, fc2_rcvd;
  logic        acknak_req, acknak_nak;
  logic [11:0] acknak_seq;
  logic [2:0]  upd_req;
  logic [23:0] fc_hdr;
  logic [35:0] fc_data;
  logic [31:0] tdata;
  logic        tvalid, tready;
  logic [1:0]  dl_status;
  logic        acknak_pending;

  pcie_dllp_tx_scheduler #(.UPDATE_FC_INTERVAL(INTERVAL)) dut (
    .clk_i(clk), .rst_i(rst), .link_up_i(link_up),
    .fc1_rcvd_i(fc1_rcvd), .fc2_rcvd_i(fc2_rcvd),
    .acknak_req_i(acknak_req), .acknak_nak_i(acknak_nak), .acknak_seq_i(acknak_seq),
    .upd_req_i(upd_req), .fc_hdr_i(fc_hdr), .fc_data_i(fc_data),
    .m_dllp_tdata(tdata), .m_dllp_tvalid(tvalid), .m_dllp_tready(tready),
    .dl_status_o(dl_status), .acknak_pending_o(acknak_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // phase: 0 link down, 1 InitFC1, 2 InitFC2, 3 active
  int          m_phase = 0;
  bit          m_pres = 0, m_pres_an = 0, m_cpl_out = 0;
  int          m_trip[$];
  int          m_idle = 0;
  int          m_cyc = 0;
  bit          m_pend[4];
  bit          m_nak = 0;
  logic [11:0] m_seq = '0;
  logic [31:0] exp_q[$];
  bit          mon_en = 0;

  logic [7:0]  init_hdr[3]  = '{8'h08, 8'h08, 8'h00};
  logic [11:0] init_data[3] = '{12'h200, 12'h080, 12'h000};

  function automatic logic [31:0] m_fc(input logic [7:0] typ, input logic [7:0] hdr,
                                       input logic [11:0] data);
    logic [7:0] b1, b2, b3;
    b1 = hdr >> 2;
    b2 = {hdr[1:0], 2'b00, data[11:8]};
    b3 = data[7:0];
    return {b3, b2, b1, typ};
  endfunction

  function automatic void present(input logic [31:0] d, input bit is_an);
    exp_q.push_back(d);
    m_pres    = 1;
    m_pres_an = is_an;
  endfunction

  function automatic void model_step();
    bit acc, free, skip;
    int s;
    logic [7:0] base;
    acc  = m_pres && tready;
    free = !m_pres || tready;
    if (acc) begin m_pres = 0; m_pres_an = 0; end
    if (!link_up) begin
      m_phase = 0; m_pres = 0; m_pres_an = 0; m_cpl_out = 0;
      m_trip.delete(); m_idle = 0; m_cyc = 0;
      foreach (m_pend[i]) m_pend[i] = 0;
      exp_q.delete();
      return;
    end
    case (m_phase)
      0: begin
        m_phase = 1; m_trip = '{0, 1, 2}; m_idle = 0; m_cpl_out = 0;
      end
      1, 2: begin
        skip = 0;
        if (m_idle > 0) m_idle--;
        if (acc && m_cpl_out) begin
          m_cpl_out = 0;
          m_trip = '{0, 1, 2};
          if ((m_phase == 1 && fc1_rcvd) || (m_phase == 2 && fc2_rcvd)) begin
            m_phase++; skip = 1; m_cyc = 0;
          end else begin
            m_idle = GAP;
          end
        end
        if (!skip && m_idle == 0 && free && m_trip.size() > 0) begin
          s = m_trip.pop_front();
          base = (m_phase == 1) ? 8'h40 : 8'hC0;
          present(m_fc(8'(base + 16 * s), init_hdr[s], init_data[s]), 0);
          if (s == 2) m_cpl_out = 1;
        end
      end
      default: begin
        m_cyc++;
        if (free) begin
          for (int k = 0; k < 4; k++) begin
            if (m_pend[k]) begin
              m_pend[k] = 0;
              if (k == 0)
                present({m_seq[7:0], 4'h0, m_seq[11:8], 8'h00, (m_nak ? 8'h10 : 8'h00)}, 1);
              else
                present(m_fc(8'(8'h70 + 16 * k), fc_hdr[8*(k-1) +: 8], fc_data[12*(k-1) +: 12]), 0);
              break;
            end
          end
        end
        if (acknak_req) begin m_pend[0] = 1; m_nak = acknak_nak; m_seq = acknak_seq; end
        for (int b = 0; b < 3; b++) if (upd_req[b]) m_pend[b+1] = 1;
        if (m_cyc % INTERVAL == 0) begin m_pend[1] = 1; m_pend[2] = 1; m_pend[3] = 1; end
      end
    endcase
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      chk("tvalid", {31'd0, tvalid}, {31'd0, exp_q.size() != 0});
      if (tvalid && exp_q.size() != 0) begin
        chk("tdata", tdata, exp_q[0]);
        if (tready) void'(exp_q.pop_front());
      end
      chk("dl_status", {30'd0, dl_status}, (m_phase == 0) ? 32'd0 : (m_phase == 3) ? 32'd2 : 32'd1);
      chk("acknak_pending", {31'd0, acknak_pending}, {31'd0, m_pend[0] || (m_pres && m_pres_an)});
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    acknak_req = 1'b0;
    upd_req    = 3'b000;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int cnt;
    rst = 1'b1; link_up = 1'b0; fc1_rcvd = 1'b0; fc2_rcvd = 1'b0;
    acknak_req = 1'b0; acknak_nak = 1'b0; acknak_seq = '0; upd_req = '0;
    fc_hdr = 24'h30_20_10; fc_data = 36'h345_234_123; tready = 1'b1;
    foreach (m_pend[i]) m_pend[i] = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_tvalid", {31'd0, tvalid}, 32'd0);
    chk("reset_tdata", tdata, 32'd0);
    chk("reset_status", {30'd0, dl_status}, 32'd0);
    chk("reset_pending", {31'd0, acknak_pending}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick(); tick();

    // Init handshake with gap repeat
    link_up = 1'b1;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (tvalid && tdata[7:0] == 8'h60 && tready) found = 1;
    end
    chk("cpl_wait_timeout", {31'd0, found}, 32'd1);
    tick();
    cnt = 0;
    while (!tvalid && cnt < 100) begin cnt++; tick(); end
    chk("init_gap_len", cnt, GAP);
    chk("after_gap_beat", tdata, 32'h0002_0240);
    tick();
    fc1_rcvd = 1'b1;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (tvalid && tdata[7:0] == 8'hC0) found = 1;
    end
    chk("initfc2_wait_timeout", {31'd0, found}, 32'd1);
    fc2_rcvd = 1'b1;
    repeat (12) tick();
    chk("active_status", {30'd0, dl_status}, 32'd2);

    // Priority: same-cycle Nak and UpdateFC P+Cpl
    acknak_req = 1'b1; acknak_nak = 1'b1; acknak_seq = 12'hABC; upd_req = 3'b101;
    tick();
    repeat (8) tick();

    // Backpressure with overwriting Ack
    acknak_req = 1'b1; acknak_nak = 1'b0; acknak_seq = 12'h123;
    tick();
    tready = 1'b0;
    tick(); tick();
    acknak_req = 1'b1; acknak_nak = 1'b0; acknak_seq = 12'h005;
    tick(); tick(); tick();
    tready = 1'b1;
    repeat (10) tick();

    // Periodic rounds with changing credits
    for (int i = 0; i < 40; i++) begin
      fc_hdr = 24'($urandom); fc_data = 36'({$urandom, $urandom});
      tick();
    end

    // Link drop while a beat is stalled
    tready = 1'b0;
    acknak_req = 1'b1; acknak_seq = 12'h777;
    tick(); tick(); tick();
    link_up = 1'b0;
    tick();
    chk("drop_tvalid", {31'd0, tvalid}, 32'd0);
    chk("drop_status", {30'd0, dl_status}, 32'd0);
    chk("drop_pending", {31'd0, acknak_pending}, 32'd0);
    link_up = 1'b1; tready = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (tvalid) found = 1;
    end
    chk("relink_timeout", {31'd0, found}, 32'd1);
    chk("relink_first_beat", tdata, 32'h0002_0240);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      tready     = ($urandom_range(0, 3) != 0);
      fc1_rcvd   = ($urandom_range(0, 3) != 0);
      fc2_rcvd   = ($urandom_range(0, 3) != 0);
      fc_hdr     = 24'($urandom);
      fc_data    = 36'({$urandom, $urandom});
      acknak_req = ($urandom_range(0, 9) == 0);
      acknak_nak = 1'($urandom);
      acknak_seq = 12'($urandom);
      upd_req    = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b000;
      if ($urandom_range(0, 299) == 0) link_up = 1'b0;
      else if (!link_up && $urandom_range(0, 2) == 0) link_up = 1'b1;
      tick();
    end

    tready = 1'b1;
    repeat (5) tick();
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
